// File: rtl/dualmem_port_arbiter.sv
// rtl/dualmem_port_arbiter.sv - post-reset RAM fill sequencer and two-requester round-robin port arbiter
// Owns one port of a 2048 x 64-bit byte-writable read-first block RAM.
module dualmem_port_arbiter #(
    parameter bit          INIT_ENABLE = 1'b1,
    parameter logic [63:0] INIT_VALUE  = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [7:0]  m0_be_i,
    input  logic [10:0] m0_addr_i,
    input  logic [63:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [63:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [7:0]  m1_be_i,
    input  logic [10:0] m1_addr_i,
    input  logic [63:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [63:0] m1_rdata_o,

    output logic        mem_en_o,
    output logic [7:0]  mem_we_o,
    output logic [10:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,

    output logic        init_done_o
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;

    logic        gnt0, gnt1, any_gnt;
    logic        sel_we;
    logic [7:0]  sel_be;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= INIT_ENABLE ? S_INIT : S_RUN;
            cnt_q        <= 11'd0;
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 11'd1;
            if (cnt_q == 11'h7FF) begin
                state_d = S_RUN;
            end
        end
    end

    // Grants are gated by the reset pin so nothing is offered while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_RUN && rst_ni) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt      = gnt0 | gnt1;
    assign last_d       = any_gnt ? gnt1 : last_q;
    assign resp_valid_d = any_gnt;
    assign resp_id_d    = gnt1;

    assign sel_we = gnt1 ? m1_we_i : m0_we_i;
    assign sel_be = gnt1 ? m1_be_i : m0_be_i;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 8'h00;
        mem_addr_o  = 11'd0;
        mem_wdata_o = 64'h0;
        if (state_q == S_INIT) begin
            mem_en_o    = rst_ni;
            mem_we_o    = rst_ni ? 8'hFF : 8'h00;
            mem_addr_o  = cnt_q;
            mem_wdata_o = INIT_VALUE;
        end else if (any_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = sel_we ? sel_be : 8'h00;
            mem_addr_o  = gnt1 ? m1_addr_i : m0_addr_i;
            mem_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = resp_valid_q & ~resp_id_q;
    assign m1_rvalid_o = resp_valid_q & resp_id_q;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign init_done_o = (state_q == S_RUN);

endmodule

// File: tb/tb_dualmem_port_arbiter.sv
// tb/tb_dualmem_port_arbiter.sv - bench for dualmem_port_arbiter with fill and no-fill instances
module tb_dualmem_port_arbiter;

    localparam logic [63:0] INIT1 = 64'hA5A5_0000_FFFF_1234;

    logic        clk;
    logic        rst_n;

    // index [d] = instance (0: no fill, 1: fill), [m] = requester
    logic        req    [2][2];
    logic        we     [2][2];
    logic [7:0]  be     [2][2];
    logic [10:0] addr   [2][2];
    logic [63:0] wdata  [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [63:0] rdata  [2][2];
    logic        en     [2];
    logic [7:0]  mwe    [2];
    logic [10:0] maddr  [2];
    logic [63:0] mwdata [2];
    logic [63:0] rdq    [2];
    logic        done   [2];

    logic [63:0] ram  [2][2048] = '{default: '0};
    logic [63:0] refm [2][2048];

    bit          run   [2];
    int          cnt   [2];
    int          mlast [2];
    bit          pv    [2];
    int          pid   [2];
    bit          pwe   [2];
    logic [63:0] pdata [2];

    int checks = 0;
    int errors = 0;

    dualmem_port_arbiter #(.INIT_ENABLE(1'b0), .INIT_VALUE(64'h0)) u_nofill (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[0][0]), .m0_we_i(we[0][0]), .m0_be_i(be[0][0]),
        .m0_addr_i(addr[0][0]), .m0_wdata_i(wdata[0][0]),
        .m0_gnt_o(gnt[0][0]), .m0_rvalid_o(rvalid[0][0]), .m0_rdata_o(rdata[0][0]),
        .m1_req_i(req[0][1]), .m1_we_i(we[0][1]), .m1_be_i(be[0][1]),
        .m1_addr_i(addr[0][1]), .m1_wdata_i(wdata[0][1]),
        .m1_gnt_o(gnt[0][1]), .m1_rvalid_o(rvalid[0][1]), .m1_rdata_o(rdata[0][1]),
        .mem_en_o(en[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]),
        .mem_wdata_o(mwdata[0]), .mem_rdata_i(rdq[0]), .init_done_o(done[0])
    );

    dualmem_port_arbiter #(.INIT_ENABLE(1'b1), .INIT_VALUE(INIT1)) u_fill (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[1][0]), .m0_we_i(we[1][0]), .m0_be_i(be[1][0]),
        .m0_addr_i(addr[1][0]), .m0_wdata_i(wdata[1][0]),
        .m0_gnt_o(gnt[1][0]), .m0_rvalid_o(rvalid[1][0]), .m0_rdata_o(rdata[1][0]),
        .m1_req_i(req[1][1]), .m1_we_i(we[1][1]), .m1_be_i(be[1][1]),
        .m1_addr_i(addr[1][1]), .m1_wdata_i(wdata[1][1]),
        .m1_gnt_o(gnt[1][1]), .m1_rvalid_o(rvalid[1][1]), .m1_rdata_o(rdata[1][1]),
        .mem_en_o(en[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]),
        .mem_wdata_o(mwdata[1]), .mem_rdata_i(rdq[1]), .init_done_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM behind each instance's port.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d]) begin
                rdq[d] <= ram[d][maddr[d]];
                for (int r = 0; r < 8; r++) begin
                    if (mwe[d][r]) ram[d][maddr[d]][8*r +: 8] <= mwdata[d][8*r +: 8];
                end
            end
        end
    end

    function automatic logic [63:0] initv(input int d);
        return (d == 1) ? INIT1 : 64'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    // Starts at a negedge; returns at a negedge with reset released.
    task automatic apply_reset();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt0", gnt[d][0], 0);
            chk("rst_gnt1", gnt[d][1], 0);
            chk("rst_rvalid0", rvalid[d][0], 0);
            chk("rst_rvalid1", rvalid[d][1], 0);
            chk("rst_mem_en", en[d], 0);
            chk("rst_mem_we", mwe[d], 0);
            chk("rst_init_done", done[d], (d == 0));
            run[d]   = (d == 0);
            cnt[d]   = 0;
            mlast[d] = 1;
            pv[d]    = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of both instances checked against the rule-level model.
    task automatic tick();
        int g [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            int k;
            k = -1;
            chk("rvalid0", rvalid[d][0], pv[d] && pid[d] == 0);
            chk("rvalid1", rvalid[d][1], pv[d] && pid[d] == 1);
            if (pv[d] && !pwe[d]) chk("rdata", rdata[d][pid[d]], pdata[d]);
            chk("init_done", done[d], run[d]);
            if (run[d]) begin
                if (req[d][0] && req[d][1]) k = 1 - mlast[d];
                else if (req[d][0])         k = 0;
                else if (req[d][1])         k = 1;
            end
            chk("gnt0", gnt[d][0], k == 0);
            chk("gnt1", gnt[d][1], k == 1);
            if (!run[d]) begin
                chk("fill_en", en[d], 1);
                chk("fill_we", mwe[d], 8'hFF);
                chk("fill_addr", maddr[d], cnt[d]);
                chk("fill_data", mwdata[d], initv(d));
            end else begin
                chk("mem_en", en[d], k >= 0);
                if (k >= 0) begin
                    chk("mem_we", mwe[d], we[d][k] ? be[d][k] : 8'h00);
                    chk("mem_addr", maddr[d], addr[d][k]);
                    if (we[d][k]) chk("mem_wdata", mwdata[d], wdata[d][k]);
                end else begin
                    chk("mem_we_idle", mwe[d], 0);
                end
            end
            g[d]  = k;
            pv[d] = (k >= 0);
            if (k >= 0) begin
                pid[d]   = k;
                pwe[d]   = we[d][k];
                mlast[d] = k;
                if (!we[d][k]) begin
                    pdata[d] = refm[d][addr[d][k]];
                end else begin
                    for (int r = 0; r < 8; r++)
                        if (be[d][k][r]) refm[d][addr[d][k]][8*r +: 8] = wdata[d][k][8*r +: 8];
                end
            end
            if (!run[d]) begin
                refm[d][cnt[d]] = initv(d);
                if (cnt[d] == 2047) run[d] = 1'b1;
                else cnt[d]++;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            if (g[d] >= 0) req[d][g[d]] = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!req[d][m] && $urandom_range(0, 1) == 1) begin
                        req[d][m]   = 1'b1;
                        we[d][m]    = 1'($urandom_range(0, 1));
                        be[d][m]    = 8'($urandom);
                        addr[d][m]  = 11'($urandom_range(0, 15));
                        wdata[d][m] = {$urandom, $urandom};
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; we[d][m] = 1'b0; be[d][m] = 8'h00;
                addr[d][m] = 11'd0; wdata[d][m] = 64'h0;
            end
            for (int a = 0; a < 2048; a++) refm[d][a] = 64'h0;
        end
        @(negedge clk);
        apply_reset();

        // No-fill instance: read granted in the first cycle out of reset.
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 11'd3;
        for (int i = 0; i < 2048; i++) begin
            if (i == 100) begin
                req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 11'h7FF;
            end
            tick();
        end
        tick();
        #1;
        chk("init_rd_valid", rvalid[1][1], 1);
        chk("init_rd_data", rdata[1][1], 64'hA5A5_0000_FFFF_1234);
        tick();

        req[1][1] = 1'b1; we[1][1] = 1'b1; be[1][1] = 8'hFF;
        addr[1][1] = 11'd16; wdata[1][1] = 64'hDEAD_BEEF_0123_4567;
        tick();
        for (int i = 0; i < 6; i++) begin
            req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 11'h7FF;
            req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 11'd16;
            #1;
            chk("alt_gnt0", gnt[1][0], (i % 2) == 0);
            chk("alt_gnt1", gnt[1][1], (i % 2) == 1);
            tick();
        end
        tick();
        tick();

        req[0][0] = 1'b1; we[0][0] = 1'b1; be[0][0] = 8'h0F;
        addr[0][0] = 11'd5; wdata[0][0] = 64'h1111_2222_3333_4444;
        tick();
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 11'd5;
        tick();
        #1;
        chk("be_rd_valid", rvalid[0][0], 1);
        chk("be_rd_data", rdata[0][0], 64'h0000_0000_3333_4444);
        tick();

        random_cycles(500);

        // Reset pulse mid-fill with a response in flight on the no-fill instance.
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            if (i == 999) begin
                req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 11'd5;
            end
            tick();
        end
        chk("pend_rvalid", rvalid[0][0], 1);
        chk("pulse_fill_addr", maddr[1], 1000);
        apply_reset();
        for (int i = 0; i < 2048; i++) tick();
        random_cycles(100);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dualmem_port_arbiter.md
# dualmem_port_arbiter

Sequencer and two-way arbiter for one port of the 2048 x 64-bit byte-writable dual-port block RAM. After reset it walks every word once to write `INIT_VALUE`, then shares the RAM port between two requesters with round-robin arbitration and a req/gnt/rvalid handshake. The other RAM port is untouched by this block.

## Interface
Parameters:
- `INIT_ENABLE`, default 1: 1 runs the post-reset fill; 0 starts directly in RUN.
- `INIT_VALUE`, default 64'h0: word written to every address during the fill.

Ports:
- `clk_i`  in  1  clock; RAM port clock is the same clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `m0_req_i` / `m1_req_i`  in  1  access request; held until granted.
- `m0_we_i` / `m1_we_i`  in  1  1 = write, 0 = read.
- `m0_be_i` / `m1_be_i`  in  8  byte enables for writes; bit r covers data[8r+7:8r].
- `m0_addr_i` / `m1_addr_i`  in  11  word address.
- `m0_wdata_i` / `m1_wdata_i`  in  64  write data.
- `m0_gnt_o` / `m1_gnt_o`  out  1  request accepted this cycle.
- `m0_rvalid_o` / `m1_rvalid_o`  out  1  response for the access granted in the previous cycle.
- `m0_rdata_o` / `m1_rdata_o`  out  64  read data; valid only with the matching rvalid.
- `mem_en_o`  out  1  RAM port enable.
- `mem_we_o`  out  8  RAM byte write enables.
- `mem_addr_o`  out  11  RAM address.
- `mem_wdata_o`  out  64  RAM write data.
- `mem_rdata_i`  in  64  RAM read data; appears one clock after the address/enable edge.
- `init_done_o`  out  1  fill complete; the arbiter is serving requesters.

## Operation
- The FSM has two states: INIT and RUN. Reset enters INIT, or RUN if `INIT_ENABLE`=0.
- INIT: an 11-bit counter runs 0..2047.
  - Each cycle drives `mem_en_o`=1, `mem_we_o`=8'hFF, `mem_addr_o`=counter and `mem_wdata_o`=`INIT_VALUE`.
  - After address 2047 is issued, the FSM moves to RUN and `init_done_o` goes high on the next cycle.
  - Both gnt outputs stay 0 in INIT; requests stay pending and are not dropped.
- RUN: grant selection is combinational from the req inputs.
  - If only one requester asserts req, that requester is granted.
  - If both assert req, the requester that was not granted most recently wins.
  - A one-bit `last` register updates on every grant. It resets so that m0 wins the first tie.
- Granted access: the winner's `we`/`be`/`addr`/`wdata` are muxed onto the RAM port with `mem_en_o`=1.
  - `mem_we_o` = be when we=1, else 8'h00.
  - With no grant: `mem_en_o`=0, `mem_we_o`=0, and the address/data outputs are don't-care.
- Response: a registered `resp_valid` and `resp_id` record the grant.
  - The next cycle, that requester gets rvalid=1, with rdata = `mem_rdata_i`.
  - Writes also produce an rvalid; their rdata is don't-care.
  - The non-selected rdata output is don't-care.
- At most one grant and one rvalid are active per cycle. Back-to-back grants are allowed with a throughput of 1 access per cycle.

## Timing
- Reset values:
  - gnt: 0.
  - rvalid: 0.
  - `init_done_o`: 0, or 1 when `INIT_ENABLE`=0.
  - `mem_en_o`: 0 during reset assertion, then 1 on the first INIT cycle.
  - `mem_we_o`: 0.
  - Counter: 0.
  - `last`: 1 (m1 granted last).
- Fill duration: exactly 2048 cycles from reset release to the first cycle in RUN.
- Access latency: gnt in cycle N; rvalid/rdata in cycle N+1. rdata shows the pre-write contents for a read granted in cycle N, and includes any write granted in N-1 (the RAM is read-first).
- Reset asserted mid-fill or mid-access: all state clears immediately; the fill restarts at address 0 and pending rvalids are lost.
- Write-after-write to the same address in consecutive cycles: the last write wins.
- The RAM's other port may write concurrently. Same-address collisions are outside this block's guarantees.

## Test plan
- Reset release with `INIT_ENABLE`=1, `INIT_VALUE`=64'hA5A5_0000_FFFF_1234:
  - Exactly 2048 write cycles at addresses 0..2047.
  - `init_done_o` rises after cycle 2048.
  - A read of addr 11'h7FF returns the init value.
- m0 writes addr 5, be 8'h0F, data 64'h1111_2222_3333_4444 over a 64'h0 fill, then reads addr 5: rdata = 64'h0000_0000_3333_4444, with rvalid one cycle after gnt.
- Both requesters hold req for 6 cycles: grants alternate m0, m1, m0, m1, m0, m1; each rvalid reaches the correct requester with its own read data.
- m1 requests during INIT at cycle 100: gnt held 0 until RUN, then granted in the first RUN cycle.
- Reset pulsed at fill address 1000:
  - The fill restarts at 0 and lasts a full 2048 cycles.
  - No rvalid is emitted during or after the pulse.
- `INIT_ENABLE`=0: `init_done_o`=1 out of reset, and an m0 read is granted in the first cycle after reset release.
